// File: rtl/double_clk_arbiter_pkg.sv
// double_clk_arbiter shared types.
// FSM encoding and requester index constants.
package double_clk_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/double_clk_arbiter_edge_cnt.sv
// clk1 falling-edge detector, period counter
// and stall watchdog for double_clk_arbiter.
module dclk_edge_cnt #(
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             run,
  input  logic             dcg_clk1,
  input  logic [LEN_W-1:0] len_q,
  output logic             last_edge,
  output logic             timeout
);

  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'(TIMEOUT - 1);

  logic             prev_q;
  logic [LEN_W-1:0] cnt_q;
  logic [TO_W-1:0]  wd_q;
  logic             fall;

  // clk1 is already in the clk domain
  assign fall = prev_q & ~dcg_clk1;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
      wd_q   <= '0;
    end else begin
      prev_q <= dcg_clk1;
      if (clr) begin
        cnt_q <= '0;
        wd_q  <= '0;
      end else if (run) begin
        if (fall) begin
          cnt_q <= cnt_q + 1'b1;
          wd_q  <= '0;
        end else begin
          wd_q <= wd_q + 1'b1;
        end
      end
    end
  end

  assign last_edge = run & fall &
    (cnt_q == len_q - 1'b1);

  // fires on the edge where wd would reach TIMEOUT
  assign timeout = run & ~fall &
    (wd_q == TO_LAST);

endmodule

// File: rtl/double_clk_arbiter.sv
// Round-robin owner of one shared double_clk_gen:
// grants bursts of N clk1 periods to two requesters.
module double_clk_arbiter
  import double_clk_arbiter_pkg::*;
#(
  parameter int LEN_W      = 8,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 1024,
  parameter int TO_W       = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [LEN_W-1:0] len0,
  input  logic             req1,
  input  logic [LEN_W-1:0] len1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             err,
  output logic             busy,
  output logic             dcg_rst,
  output logic             dcg_en,
  input  logic             dcg_clk1
);

  localparam int GAP_W =
    (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST =
    GAP_W'(GAP_CYCLES - 1);

  state_t           state_q;
  state_t           state_d;
  logic             owner_q;
  logic             last_q;
  logic [LEN_W-1:0] len_q;
  logic [GAP_W-1:0] gap_q;
  logic             done_q;
  logic             err_q;
  logic             done_d;
  logic             err_d;
  logic             pick;
  logic             last_edge;
  logic             timeout;

  dclk_edge_cnt #(
    .LEN_W   (LEN_W),
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_edge_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (state_q == ST_START),
    .run       (state_q == ST_RUN),
    .dcg_clk1  (dcg_clk1),
    .len_q     (len_q),
    .last_edge (last_edge),
    .timeout   (timeout)
  );

  always_comb begin
    pick = last_q;
    unique case (1'b1)
      req0 & req1:  pick = ~last_q;
      req0 & ~req1: pick = REQ0;
      ~req0 & req1: pick = REQ1;
      default:      pick = last_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req0 | req1)
          state_d = ST_START;
      end
      ST_START: begin
        if (len_q == '0) begin
          state_d = ST_STOP;
          done_d  = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_edge) begin
          state_d = ST_STOP;
          done_d  = 1'b1;
        end else if (timeout) begin
          state_d = ST_STOP;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
      end
      ST_STOP: begin
        if (gap_q == GAP_LAST)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= REQ0;
      last_q  <= REQ1;
      len_q   <= '0;
      gap_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (state_q == ST_IDLE && (req0 | req1)) begin
        owner_q <= pick;
        len_q   <= pick ? len1 : len0;
      end
      if (state_q == ST_STOP) begin
        last_q <= owner_q;
        gap_q  <= gap_q + 1'b1;
      end else begin
        gap_q <= '0;
      end
    end
  end

  logic owns;
  assign owns = (state_q == ST_START) |
                (state_q == ST_RUN);

  assign gnt0    = owns & (owner_q == REQ0);
  assign gnt1    = owns & (owner_q == REQ1);
  assign done0   = done_q & (owner_q == REQ0);
  assign done1   = done_q & (owner_q == REQ1);
  assign err     = err_q;
  assign busy    = (state_q != ST_IDLE);
  assign dcg_rst = (state_q == ST_START);
  assign dcg_en  = (state_q == ST_RUN);

endmodule

// File: tb/tb_double_clk_arbiter.sv
// Bench for double_clk_arbiter with a behavioural
// double_clk_gen model and burst-level reference.
module tb_double_clk_arbiter;

  localparam int LEN_W = 8;
  localparam int GAP   = 4;
  localparam int TMO   = 64;
  localparam int TO_W  = 11;
  localparam int LIMIT = 3000;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0;
  logic             req1;
  logic [LEN_W-1:0] len0;
  logic [LEN_W-1:0] len1;
  logic             gnt0, gnt1;
  logic             done0, done1;
  logic             err, busy;
  logic             dcg_rst, dcg_en;
  logic             dcg_clk1;

  int total = 0;
  int bad   = 0;

  double_clk_arbiter #(
    .LEN_W      (LEN_W),
    .GAP_CYCLES (GAP),
    .TIMEOUT    (TMO),
    .TO_W       (TO_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .len0     (len0),
    .req1     (req1),
    .len1     (len1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .done0    (done0),
    .done1    (done1),
    .err      (err),
    .busy     (busy),
    .dcg_rst  (dcg_rst),
    .dcg_en   (dcg_en),
    .dcg_clk1 (dcg_clk1)
  );

  always #5 clk = ~clk;

  // generator model: clk1 toggles every div enabled cycles
  int   div   = 10;
  int   g_cnt = 0;
  logic g_clk1 = 1'b1;
  logic stall  = 1'b0;

  always @(posedge clk) begin
    if (rst || dcg_rst) begin
      g_clk1 <= 1'b1;
      g_cnt  <= 0;
    end else if (dcg_en) begin
      if (g_cnt == div - 1) begin
        g_clk1 <= ~g_clk1;
        g_cnt  <= 0;
      end else begin
        g_cnt <= g_cnt + 1;
      end
    end
  end

  assign dcg_clk1 = stall ? 1'b0 : g_clk1;

  // last served requester; 1 means req0 wins a tie
  logic last = 1'b1;

  function automatic logic [7:0] outs();
    return {gnt0, gnt1, done0, done1,
            err, busy, dcg_rst, dcg_en};
  endfunction

  function automatic logic [7:0] mk(
    input logic g0, input logic g1,
    input logic d0, input logic d1,
    input logic e,  input logic b,
    input logic r,  input logic en);
    return {g0, g1, d0, d1, e, b, r, en};
  endfunction

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b",
             tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    chk("reset", outs(), 8'h00);
    rst  = 1'b0;
    last = 1'b1;
  endtask

  // Called at a negedge with the DUT idle and reqs set.
  // Returns at the negedge of the next idle cycle.
  task automatic burst(input int stall_after,
                       input bit mid_req1,
                       input bit drop_own);
    logic w;
    logic lp;
    int   len;
    int   edges = 0;
    int   quiet = 0;
    int   cyc   = 0;
    bit   fin   = 0;
    bit   abort = 0;
    if (req0 && req1) w = ~last;
    else              w = req1;
    len = w ? int'(len1) : int'(len0);
    @(negedge clk);
    chk("start", outs(), mk(!w, w, 0, 0, 0, 1, 1, 0));
    lp = dcg_clk1;
    if (len != 0) begin
      while (!fin) begin
        @(negedge clk);
        cyc++;
        if (mid_req1 && cyc == 1) req1 = 1'b1;
        chk("run", outs(), mk(!w, w, 0, 0, 0, 1, 0, 1));
        if (lp && !dcg_clk1) begin
          edges++;
          quiet = 0;
          if (edges == len) fin = 1;
        end else begin
          quiet++;
          if (quiet == TMO) begin
            fin   = 1;
            abort = 1;
          end
        end
        lp = dcg_clk1;
        if (stall_after > 0 && edges == stall_after)
          stall = 1'b1;
        if (!fin && cyc >= LIMIT) begin
          total++;
          bad++;
          $error("FAIL budget observed=%0d expected<%0d",
                 cyc, LIMIT);
          fin = 1;
        end
      end
    end
    @(negedge clk);
    chk("done", outs(), mk(0, 0, !w, w, abort, 1, 0, 0));
    stall = 1'b0;
    if (drop_own) begin
      if (w) req1 = 1'b0;
      else   req0 = 1'b0;
    end
    for (int i = 1; i < GAP; i++) begin
      @(negedge clk);
      chk("gap", outs(), mk(0, 0, 0, 0, 0, 1, 0, 0));
    end
    @(negedge clk);
    chk("idle", outs(), 8'h00);
    last = w;
  endtask

  initial begin
    rst  = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    len0 = '0;
    len1 = '0;
    repeat (3) @(negedge clk);
    do_reset();
    @(negedge clk);
    chk("idle0", outs(), 8'h00);

    // single request
    req0 = 1'b1;
    len0 = 8'd3;
    burst(0, 0, 1);

    // simultaneous from reset: req0 then req1
    do_reset();
    @(negedge clk);
    req0 = 1'b1;
    req1 = 1'b1;
    len0 = 8'd2;
    len1 = 8'd5;
    burst(0, 0, 1);
    burst(0, 0, 1);

    // fairness: req1 arrives during req0 burst
    req0 = 1'b1;
    len0 = 8'd4;
    len1 = 8'd3;
    burst(0, 1, 0);
    burst(0, 0, 1);
    burst(0, 0, 1);

    // zero length burst
    req0 = 1'b1;
    len0 = 8'd0;
    burst(0, 0, 1);

    // clk1 stuck low after the second period
    req0 = 1'b1;
    len0 = 8'd6;
    burst(2, 0, 1);

    // reset mid-RUN then a clean req1 burst
    req0 = 1'b1;
    len0 = 8'd10;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_run", outs(), 8'h00);
    rst  = 1'b0;
    req0 = 1'b0;
    last = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_quiet", outs(), 8'h00);
    end
    req1 = 1'b1;
    len1 = 8'd2;
    burst(0, 0, 1);

    // randomized bursts
    for (int k = 0; k < 10; k++) begin
      div  = int'($urandom_range(2, 20));
      len0 = LEN_W'($urandom_range(0, 5));
      len1 = LEN_W'($urandom_range(0, 5));
      req0 = 1'($urandom_range(0, 1));
      req1 = 1'($urandom_range(0, 1));
      if (!req0 && !req1) req1 = 1'b1;
      burst(0, 0, 1'($urandom_range(0, 1)));
    end

    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/double_clk_arbiter.md
Name: double_clk_arbiter

Overview:
- Shares one double_clk_gen instance between two requesters.
- Each requester asks for a burst of N double-clock periods.
- The block grants round-robin, resets and enables the generator, counts completed periods on the generator's clk1 output, then stops it and signals completion.
- Includes a watchdog that aborts a burst if clk1 stalls, e.g. a line held low on the open-drain bus.

Parameters:
- LEN_W, 8, width of burst length fields and the period counter.
- GAP_CYCLES, 4, idle clk cycles enforced after each burst before the next grant (generator disabled).
- TIMEOUT, 1024, max clk cycles allowed between clk1 falling edges during RUN; must be greater than 2*CLK_DIV of the generator.
- TO_W, 11, watchdog counter width; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- req0  in  1  requester 0 request level; held until done0
- len0  in  LEN_W  requester 0 burst length in clk1 periods; sampled at grant
- req1  in  1  requester 1 request level
- len1  in  LEN_W  requester 1 burst length
- gnt0  out  1  requester 0 owns generator
- gnt1  out  1  requester 1 owns generator
- done0  out  1  1-cycle pulse, requester 0 burst finished
- done1  out  1  1-cycle pulse, requester 1 burst finished
- err  out  1  1-cycle pulse coincident with done when the burst was aborted by watchdog
- busy  out  1  high in any state except IDLE
- dcg_rst  out  1  drives generator rst
- dcg_en  out  1  drives generator en
- dcg_clk1  in  1  resolved level of generator clk1 (pulled up, same clk domain)

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer favours req0; period counter and watchdog 0.
- Reset is honoured from any state, including mid-burst:
  - outputs drop to 0 the next edge;
  - no done pulse is issued.
- States: IDLE -> START -> RUN -> STOP -> IDLE.
- IDLE: if any req is high at edge t, choose the winner:
  - both high: the one not served last;
  - one high: that one.
- START (cycle t+1):
  - gntX=1, dcg_rst=1, dcg_en=0.
  - Latch lenX into len_q.
  - Clear the period counter and watchdog.
  - If len_q==0, go to STOP with doneX pulsed in the STOP entry cycle. The generator is never enabled.
  - Otherwise go to RUN.
- RUN (from cycle t+2):
  - gntX=1, dcg_rst=0, dcg_en=1.
  - Falling edge of dcg_clk1 = registered previous value 1 and current value 0 (single register, no synchroniser).
  - Each falling edge increments the counter and clears the watchdog.
  - Falling edge with counter == len_q-1: next cycle STOP, dcg_en=0, gnt drops, doneX=1 for exactly 1 cycle.
  - Watchdog reaching TIMEOUT: next cycle STOP, doneX=1 and err=1 together for 1 cycle.
- STOP:
  - dcg_en=0, dcg_rst=0, gnt=0, busy=1.
  - Stay GAP_CYCLES cycles, then IDLE.
  - Update the last-served pointer to the finished requester.
- A req drop during START/RUN is ignored; the burst completes normally.
- A req still high after done is treated as a new request, subject to round-robin.
- gnt0 and gnt1 are never high together; gntX is high only in START and RUN.
- Counter widths: period counter LEN_W bits. len_q max 2^LEN_W-1, so no wrap within a legal burst.

Decomposition:
- Shared package: state encoding (ST_IDLE, ST_START, ST_RUN, ST_STOP) and the requester index constants.
- One natural sub-module: dclk_edge_cnt.
  - Contains the falling-edge detector, period counter and watchdog.
  - Inputs: clk, rst, clr, run, dcg_clk1, len_q.
  - Outputs: last_edge, timeout.
- The arbiter FSM stays in double_clk_arbiter.

Test Plan:
- Single request: generator CLK_DIV=10, clk period 5us; req0=1, len0=3 -> gnt0 next cycle, dcg_rst 1 cycle, dcg_en high until 3rd clk1 falling edge, done0 1 cycle later, busy low 4 cycles after done0.
- Simultaneous: req0=req1=1 from reset, len0=2, len1=5 -> req0 served first (2 periods), then after the 4-cycle gap req1 (5 periods); gnt never overlaps.
- Fairness: req0 held continuously, req1 asserted during req0's burst -> next grant goes to req1, then req0.
- len0=0 -> gnt0 for 1 cycle (START), done0 pulse, dcg_en never asserts, err=0.
- Stall: external driver forces dcg_clk1=0 during RUN with TIMEOUT=64 -> done0 and err pulse together 64 cycles after the last edge, dcg_en falls.
- rst=1 mid-RUN -> next edge: all outputs 0, no done; a subsequent req1 is granted normally.
